// File: rtl/alu_exec_queue.sv
// RV32I integer/branch-compare execution unit with a small result FIFO that
// holds results until the common result bus accepts them.
module alu_exec_queue #(
    parameter int DEPTH    = 4,
    parameter int ROB_ADDR = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear,
    input  logic [5:0]          in_op,
    input  logic [31:0]         in_rs1,
    input  logic [31:0]         in_rs2,
    input  logic [ROB_ADDR-1:0] in_robid,
    output logic                alu_ready,
    output logic                out_valid,
    output logic [ROB_ADDR-1:0] out_robid,
    output logic [31:0]         out_val,
    input  logic                out_ready,
    output logic                ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [31:0] alu_calc(input logic [5:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [4:0]         sh;
        logic [31:0]        r;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[4:0];
        case (op)
            6'd1:    r = a + b;
            6'd2:    r = a - b;
            6'd3:    r = a & b;
            6'd4:    r = a | b;
            6'd5:    r = a ^ b;
            6'd6:    r = a << sh;
            6'd7:    r = a >> sh;
            6'd8:    r = $unsigned(sa >>> sh);
            6'd9:    r = {31'd0, sa < sb};
            6'd10:   r = {31'd0, a < b};
            6'd11:   r = {31'd0, a == b};
            6'd12:   r = {31'd0, a != b};
            6'd13:   r = {31'd0, sa < sb};
            6'd14:   r = {31'd0, sa >= sb};
            6'd15:   r = {31'd0, a < b};
            6'd16:   r = {31'd0, a >= b};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic [ROB_ADDR-1:0] robid_mem [DEPTH];
    logic [31:0]         val_mem   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic        enq_req, do_enq, do_deq, full;
    logic [31:0] result_p0;

    assign result_p0 = alu_calc(in_op, in_rs1, in_rs2);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_robid = out_valid ? robid_mem[head_q] : '0;
    assign out_val   = out_valid ? val_mem[head_q] : 32'd0;
    // Keep one slot free for the op already sitting in the RS output register.
    assign alu_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign ovf_err   = ovf_q;

    always_comb begin
        enq_req = rdy_in && !clear && (in_op != 6'd0);
        do_deq  = rdy_in && !clear && out_valid && out_ready;
        do_enq  = enq_req && (!full || do_deq);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q | (enq_req && full && !do_deq);
        if (rdy_in && clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_deq) head_d = head_q + 1'b1;
            if (do_enq) tail_d = tail_q + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Stage p0 -> FIFO storage; payload is never reset, visibility is gated by count.
    always_ff @(posedge clk_in) begin
        if (do_enq) begin
            robid_mem[tail_q] <= in_robid;
            val_mem[tail_q]   <= result_p0;
        end
    end

endmodule

// File: tb/tb_alu_exec_queue.sv
// Directed bench for alu_exec_queue: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_alu_exec_queue;

    localparam int DEPTH = 4;
    localparam int RA    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b1;
    logic          clr = 1'b0;
    logic [5:0]    op  = '0;
    logic [31:0]   a   = '0;
    logic [31:0]   b   = '0;
    logic [RA-1:0] id  = '0;
    logic          ordy = 1'b0;
    logic          alu_ready, out_valid, ovf_err;
    logic [RA-1:0] out_robid;
    logic [31:0]   out_val;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [RA-1:0] id;
        logic [31:0]   v;
    } ent_t;
    ent_t mq[$];
    bit   movf = 1'b0;

    alu_exec_queue #(.DEPTH(DEPTH), .ROB_ADDR(RA)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clr),
        .in_op(op), .in_rs1(a), .in_rs2(b), .in_robid(id),
        .alu_ready(alu_ready), .out_valid(out_valid), .out_robid(out_robid),
        .out_val(out_val), .out_ready(ordy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input int o, input logic [31:0] x, input logic [31:0] y);
        int sx, sy, s;
        sx = int'(x);
        sy = int'(y);
        s  = int'(y % 32);
        case (o)
            1:  return x + y;
            2:  return x - y;
            3:  return x & y;
            4:  return x | y;
            5:  return x ^ y;
            6:  return x << s;
            7:  return x >> s;
            8:  return 32'(sx >>> s);
            9:  return (sx < sy) ? 1 : 0;
            10: return (x < y) ? 1 : 0;
            11: return (x == y) ? 1 : 0;
            12: return (x != y) ? 1 : 0;
            13: return (sx < sy) ? 1 : 0;
            14: return (sx >= sy) ? 1 : 0;
            15: return (x < y) ? 1 : 0;
            16: return (x >= y) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: FIFO of {id,result} following the enqueue/dequeue rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            movf = 1'b0;
        end else if (rdy) begin
            if (clr) begin
                mq.delete();
            end else begin
                bit   pop, push;
                ent_t e;
                pop  = (mq.size() > 0) && ordy;
                push = (op != 0);
                if (push && mq.size() == DEPTH && !pop) begin
                    movf = 1'b1;
                    push = 1'b0;
                end
                if (pop) void'(mq.pop_front());
                if (push) begin
                    e.id = id;
                    e.v  = ref_alu(int'(op), a, b);
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic          ev;
        logic [RA-1:0] eid;
        logic [31:0]   eval;
        ev   = (mq.size() > 0);
        eid  = ev ? mq[0].id : '0;
        eval = ev ? mq[0].v : 32'd0;
        check("m_valid", 32'(out_valid), 32'(ev));
        check("m_robid", 32'(out_robid), 32'(eid));
        check("m_val", out_val, eval);
        check("m_alu_ready", 32'(alu_ready), 32'(mq.size() <= DEPTH - 2));
        check("m_ovf", 32'(ovf_err), 32'(movf));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input int o, input logic [31:0] x, input logic [31:0] y, input int i);
        op = 6'(o);
        a  = x;
        b  = y;
        id = RA'(i);
    endtask

    initial begin
        repeat (2) cyc();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_robid", 32'(out_robid), 0);
        check("rst_val", out_val, 0);
        check("rst_alu_ready", 32'(alu_ready), 1);
        check("rst_ovf", 32'(ovf_err), 0);
        rst = 1'b0;
        cyc();

        // 1: single ADD, one-cycle latency, popped the cycle after
        ordy = 1'b1;
        issue(1, 5, 7, 3);
        cyc();
        check("t1_valid", 32'(out_valid), 1);
        check("t1_robid", 32'(out_robid), 3);
        check("t1_val", out_val, 12);
        issue(0, 0, 0, 0);
        cyc();
        check("t1_drain", 32'(out_valid), 0);

        // 2: back-to-back ops with same-edge enqueue/dequeue
        issue(2, 0, 1, 1);                   cyc(); check("sub", out_val, 32'hFFFF_FFFF);
        issue(8, 32'h8000_0000, 33, 2);      cyc(); check("sra", out_val, 32'hC000_0000);
        issue(10, 1, 32'hFFFF_FFFF, 3);      cyc(); check("sltu", out_val, 1);
        issue(9, 1, 32'hFFFF_FFFF, 4);       cyc(); check("slt", out_val, 0);
        issue(14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5); cyc(); check("bge", out_val, 1);
        issue(6, 32'h0000_0003, 36, 6);      cyc(); check("sll", out_val, 32'h30);
        issue(7, 32'h8000_0000, 31, 7);      cyc(); check("srl", out_val, 1);
        issue(15, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 8); cyc(); check("bltu", out_val, 1);
        issue(13, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 9); cyc(); check("blt", out_val, 1);
        issue(5, 32'hF0F0_F0F0, 32'hFF00_FF00, 10); cyc(); check("xor", out_val, 32'h0FF0_0FF0);
        issue(11, 7, 7, 11);                 cyc(); check("beq", out_val, 1);
        issue(20, 5, 5, 12);                 cyc(); check("undef_val", out_val, 0);
        check("undef_id", 32'(out_robid), 12);
        issue(0, 0, 0, 0);
        cyc();

        // 3: fill with bus stalled; alu_ready falls at DEPTH-1
        ordy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            issue(1, k, 100, 8 + k);
            cyc();
            check("t3_alu_ready", 32'(alu_ready), (k + 1 <= DEPTH - 2) ? 1 : 0);
        end
        issue(0, 0, 0, 0);
        check("t3_ovf", 32'(ovf_err), 0);
        ordy = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check("t3_order", 32'(out_robid), 8 + k);
            cyc();
        end
        check("t3_empty", 32'(out_valid), 0);

        // 4: overflow drop, then full enq+deq accepted
        ordy = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            issue(4, k, 0, k);
            cyc();
        end
        issue(1, 1, 1, 9);
        cyc();
        check("t4_ovf", 32'(ovf_err), 1);
        check("t4_head", 32'(out_robid), 1);
        issue(1, 20, 22, 10);
        ordy = 1'b1;
        cyc();
        issue(0, 0, 0, 0);
        check("t4_head2", 32'(out_robid), 2);
        check("t4_full", 32'(alu_ready), 0);
        repeat (DEPTH - 1) cyc();
        check("t4_last_id", 32'(out_robid), 10);
        check("t4_last_val", out_val, 42);
        cyc();
        check("t4_ovf_held", 32'(ovf_err), 1);

        // 5: clear with concurrent issue
        ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(1, k, 1, k);
            cyc();
        end
        issue(1, 3, 3, 5);
        clr = 1'b1;
        ordy = 1'b1;
        cyc();
        clr = 1'b0;
        issue(0, 0, 0, 0);
        check("t5_valid", 32'(out_valid), 0);
        check("t5_alu_ready", 32'(alu_ready), 1);

        // 6: rdy_in low freezes everything, then async reset mid-cycle
        ordy = 1'b0;
        issue(1, 1, 2, 6);  cyc();
        issue(1, 3, 4, 7);  cyc();
        rdy = 1'b0;
        ordy = 1'b1;
        issue(2, 9, 9, 13);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t6_hold_id", 32'(out_robid), 6);
            check("t6_hold_val", out_val, 3);
        end
        issue(0, 0, 0, 0);
        rdy = 1'b1;
        ordy = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(out_valid), 0);
        check("t6_async_ovf", 32'(ovf_err), 0);
        check("t6_async_ready", 32'(alu_ready), 1);
        #1 rst = 1'b0;
        cyc();
        issue(3, 32'hFF00, 32'h0FF0, 2);
        cyc();
        issue(0, 0, 0, 0);
        check("t6_after_rst", out_val, 32'h0F00);
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
